// File: rtl/cfg_pkg.sv
// Shared constants for the clock-divider configuration interface.
// Used by both the initiator and the receiving config block so the address
// map and data layout are defined in exactly one place.
package cfg_pkg;

    localparam int unsigned CFG_TIMER_W  = 16;
    localparam int unsigned CFG_DATA_W   = 8;
    localparam int unsigned CFG_SEL_W    = 3;
    localparam int unsigned CFG_SEL_LSB  = 2;
    localparam int unsigned CFG_SEL_MSB  = 4;

    localparam logic [1:0] CFG_ADDR_NONE = 2'b00;
    localparam logic [1:0] CFG_ADDR_UART = 2'b01;
    localparam logic [1:0] CFG_ADDR_VGA  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2,
        ST_ABORT = 2'd3
    } cfg_init_state_t;

    // Place the selector into its field of the config data byte.
    function automatic logic [CFG_DATA_W-1:0] cfg_data(input logic [CFG_SEL_W-1:0] sel);
        logic [CFG_DATA_W-1:0] d;
        d = '0;
        d[CFG_SEL_MSB:CFG_SEL_LSB] = sel;
        return d;
    endfunction

endpackage

// File: rtl/cfg_timer.sv
// Loadable up-counter with terminal-match output; saturates instead of wrapping.
// Ports:
//   clk, rst      clock, async active-low reset
//   i_load        clear the count to zero (has priority over i_inc)
//   i_inc         increment the count
//   i_match       terminal value to compare against
//   o_match       count equals i_match
module cfg_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_inc,
    input  logic [W-1:0] i_match,
    output logic         o_match
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_match = (r_count == i_match);

endmodule

// File: rtl/cfg_initiator.sv
// Sequences one configuration write at a time to the clock-divider config
// block, waits for the selected target's ready, enforces an idle gap between
// writes and reports done / timeout.
// Ports:
//   clk, rst                 clock, async active-low reset
//   req_valid/target/sel     upstream request; req_ready accepts it
//   c_valid/c_addr/c_data    write strobe, address, data to the config block
//   c_UART_ready/c_VGA_ready per-target accept from the config block
//   done, err                one-cycle completion / timeout pulses
//   err_sticky               timeout flag, cleared on next accepted request
//   busy                     high outside IDLE
module cfg_initiator #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned GAP     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_target,
    input  logic [2:0] req_sel,
    output logic       req_ready,
    output logic       c_valid,
    output logic [1:0] c_addr,
    output logic [7:0] c_data,
    input  logic       c_UART_ready,
    input  logic       c_VGA_ready,
    output logic       done,
    output logic       err,
    output logic       err_sticky,
    output logic       busy
);
    import cfg_pkg::*;

    localparam logic [CFG_TIMER_W-1:0] TO_LAST  = CFG_TIMER_W'(TIMEOUT - 1);
    localparam logic [CFG_TIMER_W-1:0] GAP_LAST = CFG_TIMER_W'(GAP - 1);

    cfg_init_state_t         r_state;
    logic                    r_target;
    logic                    w_accept;
    logic                    w_sel_ready;
    logic                    w_tmr_load;
    logic                    w_tmr_inc;
    logic                    w_tmr_match;
    logic [CFG_TIMER_W-1:0]  w_tmr_last;

    // req_ready is held low while reset is asserted even though state is IDLE.
    assign req_ready   = (r_state == ST_IDLE) && rst;
    assign busy        = (r_state != ST_IDLE);
    assign w_accept    = req_valid && req_ready;
    assign w_sel_ready = r_target ? c_VGA_ready : c_UART_ready;

    // Timer restarts at zero on entry to DRIVE (from IDLE) and GAP (from DRIVE/ABORT).
    assign w_tmr_load = (r_state == ST_IDLE) || (r_state == ST_ABORT) ||
                        ((r_state == ST_DRIVE) && w_sel_ready);
    assign w_tmr_inc  = (r_state == ST_DRIVE) || (r_state == ST_GAP);
    assign w_tmr_last = (r_state == ST_DRIVE) ? TO_LAST : GAP_LAST;

    cfg_timer #(
        .W (CFG_TIMER_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_tmr_load),
        .i_inc   (w_tmr_inc),
        .i_match (w_tmr_last),
        .o_match (w_tmr_match)
    );

    // State machine with registered interface outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_target   <= 1'b0;
            c_valid    <= 1'b0;
            c_addr     <= CFG_ADDR_NONE;
            c_data     <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_target   <= req_target;
                        c_valid    <= 1'b1;
                        c_addr     <= req_target ? CFG_ADDR_VGA : CFG_ADDR_UART;
                        c_data     <= cfg_data(req_sel);
                        err_sticky <= 1'b0;
                        r_state    <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    // Ready is checked first so a ready on the last cycle still succeeds.
                    if (w_sel_ready) begin
                        done    <= 1'b1;
                        c_valid <= 1'b0;
                        c_addr  <= CFG_ADDR_NONE;
                        c_data  <= '0;
                        r_state <= ST_GAP;
                    end else if (w_tmr_match) begin
                        err        <= 1'b1;
                        err_sticky <= 1'b1;
                        c_valid    <= 1'b0;
                        c_addr     <= CFG_ADDR_NONE;
                        c_data     <= '0;
                        r_state    <= ST_ABORT;
                    end
                end
                ST_ABORT: begin
                    r_state <= ST_GAP;
                end
                ST_GAP: begin
                    if (w_tmr_match) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
